// File: rtl/display_sched.sv
// ============================================================================
// Module   : display_sched
// Brief    : Time-shares a 4-digit muxed display between live readout and
//            held one-shot messages. Optional: DISPLAY_SCHED_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module display_sched #(
  parameter int SCAN_DIV   = 50000,
  parameter int HOLD_TICKS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] note_dig,
  input  logic        msg_req,
  input  logic [15:0] msg_dig,
  output logic        msg_ack,
  output logic        msg_busy,
  output logic        scan_pulse,
  output logic [1:0]  dig_idx,
  output logic [3:0]  dig_code,
  output logic [3:0]  led_sel_n
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = $clog2(HOLD_TICKS) + 1;
  localparam logic [PW-1:0] DIV_MAX   = PW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    ST_LIVE  = 2'd0,
    ST_MSG   = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      idx_q, idx_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [15:0]     msg_q, msg_d;
  logic            ack_q, ack_d;
  logic            frame_end;
  logic            accept;
  logic            blank;
  logic [3:0]      live_nib;
  logic [3:0]      msg_nib;
`ifdef DISPLAY_SCHED_BLINK_EN
  logic [HW+3:0]   hold_ext;
`endif

  always_comb begin
    scan_pulse = (presc_q == DIV_MAX);
    presc_d    = scan_pulse ? '0 : presc_q + 1'b1;
    idx_d      = scan_pulse ? idx_q + 2'd1 : idx_q;
    frame_end  = scan_pulse && (idx_q == 2'd3);

    state_d = state_q;
    hold_d  = hold_q;
    msg_d   = msg_q;
    accept  = 1'b0;
    case (state_q)
      ST_LIVE: begin
        if (msg_req) begin
          accept  = 1'b1;
          msg_d   = msg_dig;
          hold_d  = '0;
          state_d = ST_MSG;
        end
      end
      ST_MSG: begin
        // The counter parks at its last value rather than wrapping.
        if (frame_end) begin
          if (hold_q == HOLD_LAST) state_d = ST_BLANK;
          else                     hold_d  = hold_q + 1'b1;
        end
      end
      ST_BLANK: begin
        if (frame_end) state_d = ST_LIVE;
      end
      default: state_d = ST_LIVE;
    endcase
    ack_d = accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LIVE;
      presc_q <= '0;
      idx_q   <= 2'd0;
      hold_q  <= '0;
      msg_q   <= 16'h0000;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      msg_q   <= msg_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    begin live_nib = note_dig[15:12]; msg_nib = msg_q[15:12]; end
      2'd1:    begin live_nib = note_dig[11:8];  msg_nib = msg_q[11:8];  end
      2'd2:    begin live_nib = note_dig[7:4];   msg_nib = msg_q[7:4];   end
      default: begin live_nib = note_dig[3:0];   msg_nib = msg_q[3:0];   end
    endcase

`ifdef DISPLAY_SCHED_BLINK_EN
    // Zero-extended so bit 3 exists even for short hold lengths.
    hold_ext = {4'b0000, hold_q};
    blank    = (state_q == ST_BLANK) || ((state_q == ST_MSG) && hold_ext[3]);
`else
    blank    = (state_q == ST_BLANK);
`endif

    if (blank)                  dig_code = 4'hF;
    else if (state_q == ST_MSG) dig_code = msg_nib;
    else                        dig_code = live_nib;

    if (blank) led_sel_n = 4'b1111;
    else begin
      case (idx_q)
        2'd0:    led_sel_n = 4'b0111;
        2'd1:    led_sel_n = 4'b1011;
        2'd2:    led_sel_n = 4'b1101;
        default: led_sel_n = 4'b1110;
      endcase
    end

    msg_busy = (state_q != ST_LIVE);
    msg_ack  = ack_q;
    dig_idx  = idx_q;
  end

endmodule

`default_nettype wire

// File: doc/display_sched.md
# display_sched

Time-shares the 4-digit multiplexed 7-segment display between two sources: the live note/pitch readout and one-shot messages (score, right/wrong verdict) from the game logic. Generates the digit-scan tick internally and holds each accepted message on screen for a fixed number of scan frames. After each message it inserts one blank frame, then returns to the live readout. Outputs 4-bit digit codes plus active-low digit selects; segment decoding stays in the existing downstream decoder.

## Interface
- SCAN_DIV, 50000: clk cycles per digit slot; must be ≥ 2.
- HOLD_TICKS, 500: number of full scan frames a message stays displayed; must be ≥ 1.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- note_dig  in  16  live digit codes; [15:12]=digit0 (leftmost) … [3:0]=digit3; sampled continuously.
- msg_req  in  1  level request to display msg_dig.
- msg_dig  in  16  message digit codes, same packing; captured on acceptance only.
- msg_ack  out  1  one-cycle pulse, cycle after acceptance.
- msg_busy  out  1  high in MSG and BLANK states.
- scan_pulse  out  1  one-cycle digit-advance tick.
- dig_idx  out  2  currently driven digit, 0..3.
- dig_code  out  4  code for current digit; 4'hF when blanked.
- led_sel_n  out  4  active-low digit select.

## Operation
- Prescaler counts 0..SCAN_DIV-1 and wraps. scan_pulse=1 in the cycle the count equals SCAN_DIV-1.
- dig_idx increments on scan_pulse and wraps 3→0.
- Frame boundary: scan_pulse while dig_idx==3.
- led_sel_n decode: idx0=4'b0111, idx1=4'b1011, idx2=4'b1101, idx3=4'b1110. Blanked: 4'b1111.
- States:
  - LIVE: dig_code = note_dig nibble for dig_idx. If msg_req=1, accept: latch msg_dig, clear hold counter, go to MSG.
  - MSG: dig_code = latched nibble. Hold counter increments at each frame boundary. At the frame boundary where it equals HOLD_TICKS-1, go to BLANK. The first, partial frame counts as frame 0.
  - BLANK: led_sel_n=4'b1111, dig_code=4'hF. At the next frame boundary, go to LIVE.
- msg_req in MSG/BLANK is ignored, with no ack and no latch. A requester holding req high is accepted on the first LIVE cycle.
- Hold counter width is $clog2(HOLD_TICKS)+1; it never wraps in MSG.
- Prescaler and dig_idx run freely in all states and are not reset by state changes.

## Timing
- Reset values: prescaler=0, dig_idx=0, state=LIVE, hold counter=0, latched msg=0, msg_ack=0, msg_busy=0, scan_pulse=0, led_sel_n=4'b0111, dig_code=note_dig[15:12].
- dig_code, led_sel_n and msg_busy are combinational from registered state, dig_idx and latched data.
- dig_code tracks note_dig changes in the same cycle while in LIVE.
- Acceptance cycle T (LIVE, msg_req=1): at T+1, state=MSG, msg_ack=1, msg_busy=1, and the display shows msg_dig. msg_ack returns to 0 at T+2.
- Acceptance coinciding with a frame boundary: the boundary does not count toward HOLD_TICKS.
- rst mid-MSG/BLANK: next cycle is LIVE, latch discarded, no ack issued.
- rst coinciding with acceptance: reset wins.

## Configuration
- DISPLAY_SCHED_BLINK_EN defined: in MSG, the display is blanked (4'b1111 / 4'hF) whenever hold counter bit 3 is 1, i.e. frames 8–15, 24–31, …. The hold length is unchanged.
- Undefined: MSG display is steady for all HOLD_TICKS frames.
- LIVE and BLANK behaviour is identical in both builds.

## Test plan
- Reset/scan (SCAN_DIV=4): release rst → scan_pulse at cycles 3,7,11,…; dig_idx 0,1,2,3,0; led_sel_n 0111,1011,1101,1110 repeating.
- Live readout: note_dig=16'h8109 → dig_code 8,1,0,9 across one frame. Change note_dig to 16'h0906 mid-frame → the new nibble appears the same cycle.
- Message (HOLD_TICKS=3): msg_req pulse with msg_dig=16'h1234 → msg_ack high exactly one cycle. Codes 1,2,3,4 through 3 frame boundaries, then one full frame of led_sel_n=1111, then 8,1,0,9 again; msg_busy falls on LIVE entry.
- Request while busy: msg_req held high with 16'h5678 during MSG → no ack. Accepted on the first LIVE cycle, second ack follows, and 5,6,7,8 is displayed.
- Reset mid-MSG: assert rst one cycle during MSG → LIVE next cycle, msg_busy=0, live codes shown, no ack pulse.
- Blink build (DISPLAY_SCHED_BLINK_EN, HOLD_TICKS=20): frames 0–7 show message, 8–15 blanked, 16–19 show message, then BLANK and LIVE. In the non-macro build, all 20 frames are shown.
